// File: rtl/reg_write_arbiter_if.sv
// Requester-side write bus for reg_write_arbiter: packed valid/idx/data from
// NUM_REQ producers and the per-requester grant returned by the arbiter.
interface reg_write_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 16,
    parameter int IDX_W   = 3
) ();
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*IDX_W-1:0]  req_idx;
    logic [NUM_REQ*DATA_W-1:0] req_data;

    // Producers drive requests and observe grants.
    modport master (
        output req_valid,
        output req_idx,
        output req_data,
        input  req_ready
    );

    // The arbiter observes requests and drives grants.
    modport slave (
        input  req_valid,
        input  req_idx,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbitration of NUM_REQ producers onto the
// single register_bank write port, with a registered one-hot write strobe,
// a stall input and a saturating contention counter for performance debug.
module reg_write_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 3,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                hold,
    reg_write_arbiter_if.slave  req,
    output logic [NUM_REGS-1:0] en,
    output logic [DATA_W-1:0]   to_dest_reg,
    output logic [2:0]          last_grant,
    output logic [CNT_W-1:0]    contention_cnt
);
    // Round-robin pointer: the requester searched first this cycle.
    logic [2:0]          ptr;
    // Valid vector zero-extended to 8 so a 3-bit candidate index is always legal.
    logic [7:0]          valid_pad;
    logic                grant_found;
    logic [2:0]          grant_idx;
    logic [2:0]          cand;
    logic [IDX_W-1:0]    sel_idx;
    logic [DATA_W-1:0]   sel_data;
    logic [NUM_REGS-1:0] en_next;
    logic                contended;

    assign valid_pad = 8'(req.req_valid);

    // Cyclic search from ptr for the first valid requester; nothing is granted
    // while stalled or held in reset.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 3'((32'(ptr) + k) % NUM_REQ);
            if (!grant_found && valid_pad[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        if (!reset_n || hold) begin
            grant_found = 1'b0;
            grant_idx   = '0;
        end
    end

    assign req.req_ready = grant_found ? (NUM_REQ'(1) << grant_idx) : '0;

    // Select the granted requester's index and data, and decode the index;
    // indices beyond the bank size decode to no strobe at all.
    always_comb begin
        sel_idx  = req.req_idx[int'(grant_idx)*IDX_W +: IDX_W];
        sel_data = req.req_data[int'(grant_idx)*DATA_W +: DATA_W];
        en_next  = '0;
        if (32'(sel_idx) < NUM_REGS) begin
            en_next = NUM_REGS'(1) << sel_idx;
        end
    end

    assign contended = !hold && ($countones(req.req_valid) >= 2);

    // Registered write port, pointer advance and contention counting; an
    // asynchronous reset also cancels any in-flight write strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr            <= '0;
            en             <= '0;
            to_dest_reg    <= '0;
            last_grant     <= '0;
            contention_cnt <= '0;
        end else begin
            if (grant_found) begin
                ptr         <= 3'((32'(grant_idx) + 1) % NUM_REQ);
                en          <= en_next;
                to_dest_reg <= sel_data;
                last_grant  <= grant_idx;
            end else begin
                en <= '0;
            end
            if (contended && (contention_cnt != '1)) begin
                contention_cnt <= contention_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed testbench for reg_write_arbiter: a default instance plus a small
// instance (CNT_W=2, NUM_REGS=6) for saturation and out-of-range indices.
module tb_reg_write_arbiter;
    logic        clk;
    logic        reset_n;
    logic        hold0;
    logic        hold1;
    logic [7:0]  en0;
    logic [15:0] dat0;
    logic [2:0]  lg0;
    logic [7:0]  cnt0;
    logic [5:0]  en1;
    logic [15:0] dat1;
    logic [2:0]  lg1;
    logic [1:0]  cnt1;
    logic [15:0] bank [8];
    int          total;
    int          bad;

    reg_write_arbiter_if #(.NUM_REQ(3), .DATA_W(16), .IDX_W(3)) bus0 ();
    reg_write_arbiter_if #(.NUM_REQ(3), .DATA_W(16), .IDX_W(3)) bus1 ();

    reg_write_arbiter #(.NUM_REQ(3), .DATA_W(16), .NUM_REGS(8), .IDX_W(3), .CNT_W(8)) u0 (
        .clk(clk), .reset_n(reset_n), .hold(hold0), .req(bus0.slave),
        .en(en0), .to_dest_reg(dat0), .last_grant(lg0), .contention_cnt(cnt0)
    );

    reg_write_arbiter #(.NUM_REQ(3), .DATA_W(16), .NUM_REGS(6), .IDX_W(3), .CNT_W(2)) u1 (
        .clk(clk), .reset_n(reset_n), .hold(hold1), .req(bus1.slave),
        .en(en1), .to_dest_reg(dat1), .last_grant(lg1), .contention_cnt(cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Simple register bank model fed by the default instance.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (en0[i]) bank[i] <= dat0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset_n = 1'b0;
        hold0 = 1'b0; hold1 = 1'b0;
        bus0.req_valid = '0; bus0.req_idx = '0; bus0.req_data = '0;
        bus1.req_valid = '0; bus1.req_idx = '0; bus1.req_data = '0;
        #2;
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        tick();
        reset_n = 1'b0;
        bus0.req_valid = 3'b111;
        bus1.req_valid = 3'b111;
        #1;
        total++; if (bus0.req_ready !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b exp=000", bus0.req_ready); end
        total++; if (bus1.req_ready !== 3'b000) begin bad++; $display("FAIL reset_ready1 got=%b exp=000", bus1.req_ready); end
        total++; if (en0 !== 8'h00) begin bad++; $display("FAIL reset_en got=%h exp=00", en0); end
        total++; if (dat0 !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h exp=0000", dat0); end
        total++; if (cnt0 !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt0); end
        total++; if (lg0 !== 3'd0) begin bad++; $display("FAIL reset_last got=%0d exp=0", lg0); end
        bus0.req_valid = '0;
        bus1.req_valid = '0;
        reset_n = 1'b1;
        tick();
        tick();
        total++; if (en0 !== 8'h00) begin bad++; $display("FAIL idle_en got=%h exp=00", en0); end
        total++; if (cnt0 !== 8'd0) begin bad++; $display("FAIL idle_cnt got=%0d exp=0", cnt0); end
    endtask

    task automatic test_single();
        do_reset();
        bus0.req_valid = 3'b001;
        bus0.req_idx   = {3'd0, 3'd0, 3'd1};
        bus0.req_data  = {16'h0000, 16'h0000, 16'h0001};
        #1;
        total++; if (bus0.req_ready !== 3'b001) begin bad++; $display("FAIL single_ready got=%b exp=001", bus0.req_ready); end
        tick();
        bus0.req_valid = '0;
        total++; if (en0 !== 8'b0000_0010) begin bad++; $display("FAIL single_en got=%b exp=00000010", en0); end
        total++; if (dat0 !== 16'h0001) begin bad++; $display("FAIL single_data got=%h exp=0001", dat0); end
        total++; if (lg0 !== 3'd0) begin bad++; $display("FAIL single_last got=%0d exp=0", lg0); end
        tick();
        total++; if (en0 !== 8'h00) begin bad++; $display("FAIL single_en_drop got=%h exp=00", en0); end
        total++; if (dat0 !== 16'h0001) begin bad++; $display("FAIL single_data_hold got=%h exp=0001", dat0); end
        total++; if (bank[1] !== 16'h0001) begin bad++; $display("FAIL single_bank got=%h exp=0001", bank[1]); end
    endtask

    task automatic test_round_robin();
        logic [2:0]  rdy_e [4];
        logic [7:0]  en_e  [4];
        logic [15:0] dat_e [4];
        logic [2:0]  lg_e  [4];
        rdy_e = '{3'b001, 3'b010, 3'b100, 3'b001};
        en_e  = '{8'h01, 8'h08, 8'h80, 8'h01};
        dat_e = '{16'hA000, 16'hB001, 16'hC002, 16'hA000};
        lg_e  = '{3'd0, 3'd1, 3'd2, 3'd0};
        do_reset();
        bus0.req_valid = 3'b111;
        bus0.req_idx   = {3'd7, 3'd3, 3'd0};
        bus0.req_data  = {16'hC002, 16'hB001, 16'hA000};
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (bus0.req_ready !== rdy_e[k]) begin bad++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, bus0.req_ready, rdy_e[k]); end
            tick();
            total++; if (en0 !== en_e[k]) begin bad++; $display("FAIL rr_en[%0d] got=%h exp=%h", k, en0, en_e[k]); end
            total++; if (dat0 !== dat_e[k]) begin bad++; $display("FAIL rr_data[%0d] got=%h exp=%h", k, dat0, dat_e[k]); end
            total++; if (lg0 !== lg_e[k]) begin bad++; $display("FAIL rr_last[%0d] got=%0d exp=%0d", k, lg0, lg_e[k]); end
            total++; if (cnt0 !== 8'(k + 1)) begin bad++; $display("FAIL rr_cnt[%0d] got=%0d exp=%0d", k, cnt0, k + 1); end
        end
        bus0.req_valid = '0;
    endtask

    task automatic test_hold();
        do_reset();
        hold0 = 1'b1;
        bus0.req_valid = 3'b110;
        bus0.req_idx   = {3'd6, 3'd5, 3'd0};
        bus0.req_data  = {16'h6666, 16'h5555, 16'h0000};
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (bus0.req_ready !== 3'b000) begin bad++; $display("FAIL hold_ready[%0d] got=%b exp=000", k, bus0.req_ready); end
            tick();
            total++; if (en0 !== 8'h00) begin bad++; $display("FAIL hold_en[%0d] got=%h exp=00", k, en0); end
            total++; if (cnt0 !== 8'd0) begin bad++; $display("FAIL hold_cnt[%0d] got=%0d exp=0", k, cnt0); end
        end
        hold0 = 1'b0;
        #1;
        total++; if (bus0.req_ready !== 3'b010) begin bad++; $display("FAIL unhold_ready got=%b exp=010", bus0.req_ready); end
        tick();
        total++; if (en0 !== 8'b0010_0000) begin bad++; $display("FAIL unhold_en got=%b exp=00100000", en0); end
        total++; if (dat0 !== 16'h5555) begin bad++; $display("FAIL unhold_data got=%h exp=5555", dat0); end
        total++; if (lg0 !== 3'd1) begin bad++; $display("FAIL unhold_last got=%0d exp=1", lg0); end
        total++; if (cnt0 !== 8'd1) begin bad++; $display("FAIL unhold_cnt got=%0d exp=1", cnt0); end
        #1;
        total++; if (bus0.req_ready !== 3'b100) begin bad++; $display("FAIL unhold_next_ready got=%b exp=100", bus0.req_ready); end
        tick();
        total++; if (en0 !== 8'b0100_0000) begin bad++; $display("FAIL unhold_next_en got=%b exp=01000000", en0); end
        total++; if (cnt0 !== 8'd2) begin bad++; $display("FAIL unhold_next_cnt got=%0d exp=2", cnt0); end
        bus0.req_valid = '0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus0.req_valid = 3'b011;
        bus0.req_idx   = {3'd0, 3'd4, 3'd4};
        bus0.req_data  = {16'h0000, 16'h2222, 16'h1111};
        #1;
        total++; if (bus0.req_ready !== 3'b001) begin bad++; $display("FAIL b2b_ready0 got=%b exp=001", bus0.req_ready); end
        tick();
        total++; if (en0 !== 8'h10) begin bad++; $display("FAIL b2b_en0 got=%h exp=10", en0); end
        total++; if (dat0 !== 16'h1111) begin bad++; $display("FAIL b2b_data0 got=%h exp=1111", dat0); end
        #1;
        total++; if (bus0.req_ready !== 3'b010) begin bad++; $display("FAIL b2b_ready1 got=%b exp=010", bus0.req_ready); end
        tick();
        bus0.req_valid = '0;
        total++; if (en0 !== 8'h10) begin bad++; $display("FAIL b2b_en1 got=%h exp=10", en0); end
        total++; if (dat0 !== 16'h2222) begin bad++; $display("FAIL b2b_data1 got=%h exp=2222", dat0); end
        tick();
        total++; if (en0 !== 8'h00) begin bad++; $display("FAIL b2b_en_drop got=%h exp=00", en0); end
        total++; if (bank[4] !== 16'h2222) begin bad++; $display("FAIL b2b_bank got=%h exp=2222", bank[4]); end
    endtask

    task automatic test_saturation();
        logic [1:0] cnt_e [5];
        cnt_e = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        bus1.req_valid = 3'b011;
        bus1.req_idx   = {3'd0, 3'd1, 3'd2};
        bus1.req_data  = {16'h0000, 16'h0011, 16'h0022};
        for (int k = 0; k < 5; k++) begin
            tick();
            total++; if (cnt1 !== cnt_e[k]) begin bad++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", k, cnt1, cnt_e[k]); end
        end
        bus1.req_valid = '0;
        tick();
        total++; if (cnt1 !== 2'd3) begin bad++; $display("FAIL sat_cnt_idle got=%0d exp=3", cnt1); end
    endtask

    task automatic test_out_of_range();
        do_reset();
        bus1.req_valid = 3'b001;
        bus1.req_idx   = {3'd0, 3'd0, 3'd7};
        bus1.req_data  = {16'h0000, 16'h0000, 16'h7777};
        #1;
        total++; if (bus1.req_ready !== 3'b001) begin bad++; $display("FAIL oor_ready got=%b exp=001", bus1.req_ready); end
        tick();
        total++; if (en1 !== 6'b000000) begin bad++; $display("FAIL oor7_en got=%b exp=000000", en1); end
        total++; if (dat1 !== 16'h7777) begin bad++; $display("FAIL oor7_data got=%h exp=7777", dat1); end
        bus1.req_idx  = {3'd0, 3'd0, 3'd6};
        bus1.req_data = {16'h0000, 16'h0000, 16'h6666};
        #1;
        total++; if (bus1.req_ready !== 3'b001) begin bad++; $display("FAIL oor6_ready got=%b exp=001", bus1.req_ready); end
        tick();
        total++; if (en1 !== 6'b000000) begin bad++; $display("FAIL oor6_en got=%b exp=000000", en1); end
        total++; if (dat1 !== 16'h6666) begin bad++; $display("FAIL oor6_data got=%h exp=6666", dat1); end
        bus1.req_idx  = {3'd0, 3'd0, 3'd5};
        bus1.req_data = {16'h0000, 16'h0000, 16'h5555};
        tick();
        total++; if (en1 !== 6'b100000) begin bad++; $display("FAIL top_idx_en got=%b exp=100000", en1); end
        total++; if (dat1 !== 16'h5555) begin bad++; $display("FAIL top_idx_data got=%h exp=5555", dat1); end
        bus1.req_valid = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus0.req_valid = 3'b010;
        bus0.req_idx   = {3'd0, 3'd2, 3'd0};
        bus0.req_data  = {16'h0000, 16'h0404, 16'h0000};
        #1;
        total++; if (bus0.req_ready !== 3'b010) begin bad++; $display("FAIL mid_ready got=%b exp=010", bus0.req_ready); end
        tick();
        bus0.req_valid = '0;
        total++; if (en0 !== 8'h04) begin bad++; $display("FAIL mid_en_pre got=%h exp=04", en0); end
        reset_n = 1'b0;
        bus0.req_valid = 3'b111;
        bus0.req_idx   = {3'd7, 3'd3, 3'd1};
        bus0.req_data  = {16'h0C0C, 16'h0B0B, 16'h0A0A};
        #1;
        total++; if (en0 !== 8'h00) begin bad++; $display("FAIL mid_en_cancel got=%h exp=00", en0); end
        total++; if (lg0 !== 3'd0) begin bad++; $display("FAIL mid_last got=%0d exp=0", lg0); end
        total++; if (bus0.req_ready !== 3'b000) begin bad++; $display("FAIL mid_ready_rst got=%b exp=000", bus0.req_ready); end
        reset_n = 1'b1;
        #1;
        total++; if (bus0.req_ready !== 3'b001) begin bad++; $display("FAIL mid_first_ready got=%b exp=001", bus0.req_ready); end
        tick();
        total++; if (en0 !== 8'h02) begin bad++; $display("FAIL mid_first_en got=%h exp=02", en0); end
        total++; if (dat0 !== 16'h0A0A) begin bad++; $display("FAIL mid_first_data got=%h exp=0a0a", dat0); end
        bus0.req_valid = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad   = 0;
        reset_n = 1'b0;
        hold0 = 1'b0; hold1 = 1'b0;
        bus0.req_valid = '0; bus0.req_idx = '0; bus0.req_data = '0;
        bus1.req_valid = '0; bus1.req_idx = '0; bus1.req_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_back_to_back();
        test_saturation();
        test_out_of_range();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
